// File: rtl/cpu_pkg.sv
// +----------------------------------------------------------------------+
// | cpu_pkg: opcode encodings, issuer state type and legality helper     |
// | shared by the opcode issuer and the control-unit decoder.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

   localparam int OP_W = 6;

   localparam logic [OP_W-1:0] OP_ADD = 6'h00;
   localparam logic [OP_W-1:0] OP_SUB = 6'h01;
   localparam logic [OP_W-1:0] OP_AND = 6'h02;
   localparam logic [OP_W-1:0] OP_OR  = 6'h03;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } issuer_state_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

endpackage

`default_nettype wire

// File: rtl/opcode_buffer.sv
// +----------------------------------------------------------------------+
// | opcode_buffer: DEPTH x OP_W program store, synchronous write,        |
// | asynchronous read, synchronous active-low clear to zero.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module opcode_buffer
   import cpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = cpu_pkg::OP_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/opcode_issuer.sv
// +----------------------------------------------------------------------+
// | opcode_issuer: streams a preloaded opcode program over valid/ready.  |
// | Option OPCODE_ISSUER_SKIP_ILLEGAL_EN: drop illegal entries as bubbles.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module opcode_issuer
   import cpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int OP_W  = cpu_pkg::OP_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_en,
   input  logic [$clog2(DEPTH)-1:0] load_addr,
   input  logic [OP_W-1:0]          load_opcode,
   input  logic                     start,
   input  logic [$clog2(DEPTH):0]   prog_len,
   output logic                     op_valid,
   input  logic                     op_ready,
   output logic [OP_W-1:0]          opcode,
   output logic [$clog2(DEPTH)-1:0] pc,
   output logic                     busy,
   output logic                     done,
   output logic [7:0]               skip_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   issuer_state_t   state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [LW-1:0]   len_q, len_d;
   logic [7:0]      skip_cnt_q, skip_cnt_d;

   logic            w_buf_we;
   logic            w_legal;
   logic            w_issue;
   logic            w_advance;
   logic            w_last;

   opcode_buffer #(
      .DEPTH (DEPTH),
      .WIDTH (OP_W)
   ) u_buffer (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (w_buf_we),
      .waddr (load_addr),
      .wdata (load_opcode),
      .raddr (pc_q),
      .rdata (opcode)
   );

   always_comb begin
      w_legal = 1'b1;
`ifdef OPCODE_ISSUER_SKIP_ILLEGAL_EN
      w_legal = is_legal_op(opcode);
`endif
   end

   assign w_issue   = (state_q == ST_ISSUE);
   assign op_valid  = w_issue && w_legal;
   // An illegal entry advances pc on its own, costing one bubble cycle.
   assign w_advance = (op_valid && op_ready) || (w_issue && !w_legal);
   assign w_last    = ({1'b0, pc_q} == (len_q - LW'(1)));
   assign w_buf_we  = load_en && (state_q == ST_IDLE);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      len_d      = len_q;
      skip_cnt_d = skip_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               skip_cnt_d = '0;
               if (prog_len != '0) begin
                  state_d = ST_ISSUE;
                  len_d   = prog_len;
                  pc_d    = '0;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_ISSUE: begin
            if (w_advance) begin
               if (w_last) begin
                  state_d = ST_DONE;
               end else begin
                  pc_d = pc_q + AW'(1);
               end
               if (!w_legal && (skip_cnt_q != 8'hFF)) begin
                  skip_cnt_d = skip_cnt_q + 8'd1;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         len_q      <= '0;
         skip_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         len_q      <= len_d;
         skip_cnt_q <= skip_cnt_d;
      end
   end

   assign pc       = pc_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign skip_cnt = skip_cnt_q;

endmodule

`default_nettype wire
